// File: rtl/stack_pkg.sv
// Shared encodings for the LIFO stack controller.
// Latency: n/a (types only).
// Backpressure: n/a.
package stack_pkg;

  // Command opcodes as they appear on cmd_op.
  typedef enum logic [1:0] {
    OP_PUSH  = 2'b00,
    OP_POP   = 2'b01,
    OP_PEEK  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  // Controller sequencing states.
  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_e;

endpackage

// File: rtl/stack_ctrl_if.sv
// Command/response bundle between a command source and the stack controller.
// Latency: n/a (wires only).
// Backpressure: cmd_ready gates cmd_valid; the response side has no backpressure.
// Ports: master = command source, slave = stack controller.
interface stack_ctrl_if
  import stack_pkg::*;
#(
  parameter int DATA_WIDTH = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  op_e                   cmd_op;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/stack_ram.sv
// Single-port RAM: writes and registers its read address on the falling clock edge.
// Latency: read data valid half a cycle after the address is presented.
// Backpressure: none; one access per cycle.
// Ports: clk, addr, data_in, we (active-low write enable), data_out.
module stack_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] data_out
);
  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] addr_d;

  always_comb addr_d = addr;

  always_ff @(negedge clk) begin
    if (!we) mem[addr] <= data_in;
    addr_q <= addr_d;
  end

  assign data_out = mem[addr_q];
endmodule

// File: rtl/stack_top.sv
// Stack wrapper: controller plus its single-port RAM on a shared clock.
// Latency: as stack_ctrl (response one cycle after the access cycle).
// Backpressure: as stack_ctrl (cmd_ready low during the access cycle).
// Ports: clk, rst_n, cmd (slave modport), count/full/empty status.
module stack_top
  import stack_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] STACK_BASE  = '0,
  parameter int                    STACK_DEPTH = 256
) (
  input  logic                             clk,
  input  logic                             rst_n,
  stack_ctrl_if.slave                      cmd,
  output logic [$clog2(STACK_DEPTH+1)-1:0] count,
  output logic                             full,
  output logic                             empty
);
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_data_in;
  logic [DATA_WIDTH-1:0] ram_data_out;
  logic                  ram_we_n;

  stack_ctrl #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .STACK_BASE (STACK_BASE),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd         (cmd),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .ram_addr    (ram_addr),
    .ram_data_in (ram_data_in),
    .ram_we_n    (ram_we_n),
    .ram_data_out(ram_data_out)
  );

  stack_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .addr    (ram_addr),
    .data_in (ram_data_in),
    .we      (ram_we_n),
    .data_out(ram_data_out)
  );
endmodule

// File: rtl/stack_ctrl.sv
// LIFO stack controller turning push/pop/peek/clear commands into single-port RAM cycles.
// Latency: accept at edge T, response pulse in the cycle after edge T+1.
// Backpressure: cmd_ready low during the one-cycle RAM access; responses cannot be stalled.
// Ports: clk, rst_n (sync, active-low), cmd (slave modport), count/full/empty, ram_* to the RAM.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] STACK_BASE  = '0,
  parameter int                    STACK_DEPTH = 256
) (
  input  logic                               clk,
  input  logic                               rst_n,
  stack_ctrl_if.slave                        cmd,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   count,
  output logic                               full,
  output logic                               empty,
  output logic [ADDR_WIDTH-1:0]              ram_addr,
  output logic [DATA_WIDTH-1:0]              ram_data_in,
  output logic                               ram_we_n,
  input  logic [DATA_WIDTH-1:0]              ram_data_out
);
  localparam int             CW      = $clog2(STACK_DEPTH + 1);
  localparam logic [CW-1:0]  DEPTH_C = CW'(STACK_DEPTH);

  if (STACK_DEPTH < 1 ||
      (longint'(STACK_BASE) + longint'(STACK_DEPTH)) > (longint'(1) << ADDR_WIDTH)) begin : g_bad_params
    $error("stack_ctrl: stack region does not fit the RAM address space");
  end

  state_e                state_q, state_d;
  logic [CW-1:0]         sp_q, sp_d;
  op_e                   op_q, op_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_data_in_q, ram_data_in_d;
  logic                  ram_we_n_q, ram_we_n_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  full_w, empty_w;

  assign full_w  = (sp_q == DEPTH_C);
  assign empty_w = (sp_q == '0);

  always_comb begin
    state_d       = state_q;
    sp_d          = sp_q;
    op_d          = op_q;
    err_d         = err_q;
    ram_addr_d    = ram_addr_q;
    ram_data_in_d = ram_data_in_q;
    ram_we_n_d    = ram_we_n_q;
    rsp_valid_d   = 1'b0;
    rsp_err_d     = 1'b0;
    rsp_data_d    = '0;
    case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid) begin
          state_d    = S_ACCESS;
          op_d       = cmd.cmd_op;
          err_d      = 1'b0;
          ram_we_n_d = 1'b1;
          // The error decision is taken here so the RAM is never touched by a failing op.
          case (cmd.cmd_op)
            OP_PUSH: begin
              if (full_w) err_d = 1'b1;
              else begin
                ram_addr_d    = STACK_BASE + ADDR_WIDTH'(sp_q);
                ram_data_in_d = cmd.cmd_data;
                ram_we_n_d    = 1'b0;
              end
            end
            OP_POP, OP_PEEK: begin
              if (empty_w) err_d = 1'b1;
              else ram_addr_d = STACK_BASE + ADDR_WIDTH'(sp_q) - ADDR_WIDTH'(1);
            end
            default: ;
          endcase
        end
      end
      S_ACCESS: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
        ram_we_n_d  = 1'b1;
        if (err_q) rsp_err_d = 1'b1;
        else begin
          case (op_q)
            OP_PUSH:  sp_d = sp_q + CW'(1);
            OP_POP: begin
              rsp_data_d = ram_data_out;
              sp_d       = sp_q - CW'(1);
            end
            OP_PEEK:  rsp_data_d = ram_data_out;
            OP_CLEAR: sp_d = '0;
            default: ;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      sp_q          <= '0;
      op_q          <= OP_PUSH;
      err_q         <= 1'b0;
      ram_addr_q    <= STACK_BASE;
      ram_data_in_q <= '0;
      ram_we_n_q    <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      sp_q          <= sp_d;
      op_q          <= op_d;
      err_q         <= err_d;
      ram_addr_q    <= ram_addr_d;
      ram_data_in_q <= ram_data_in_d;
      ram_we_n_q    <= ram_we_n_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_data_q    <= rsp_data_d;
    end
  end

  assign cmd.cmd_ready = (state_q == S_IDLE);
  assign cmd.rsp_valid = rsp_valid_q;
  assign cmd.rsp_err   = rsp_err_q;
  assign cmd.rsp_data  = rsp_data_q;
  assign count         = sp_q;
  assign full          = full_w;
  assign empty         = empty_w;
  assign ram_addr      = ram_addr_q;
  assign ram_data_in   = ram_data_in_q;
  assign ram_we_n      = ram_we_n_q;
endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

LIFO stack controller sequencing the single-port RAM through its `addr` / `data_in` / active-low `we` / `data_out` ports. It turns push/pop/peek/clear commands into RAM cycles and keeps the stack pointer and full/empty state. It sits between the command source and the RAM; the `stack_top` wrapper instantiates both.

## Interface
- `DATA_WIDTH`, 8: word width; equals the RAM's `DATA_WIDTH`.
- `ADDR_WIDTH`, 16: RAM address width.
- `STACK_BASE`, 16'h0000: RAM address of stack slot 0.
- `STACK_DEPTH`, 256: slot count. Elaboration error if `STACK_BASE + STACK_DEPTH > 2**ADDR_WIDTH` or `STACK_DEPTH < 1`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE; accept = `cmd_valid & cmd_ready` at a rising edge.
- `cmd_op` in 2: 00 PUSH, 01 POP, 10 PEEK, 11 CLEAR.
- `cmd_data` in DATA_WIDTH: PUSH data.
- `rsp_valid` out 1: one-cycle response pulse; no backpressure.
- `rsp_data` out DATA_WIDTH: POP/PEEK result; 0 for other ops and errors.
- `rsp_err` out 1: qualifies `rsp_valid`; set for PUSH when full, and for POP/PEEK when empty.
- `count` out CW: occupied slots, CW = `$clog2(STACK_DEPTH+1)`.
- `full` out 1: `count == STACK_DEPTH`.
- `empty` out 1: `count == 0`.
- `ram_addr` out ADDR_WIDTH: registered; drives RAM `addr`.
- `ram_data_in` out DATA_WIDTH: registered; drives RAM `data_in`.
- `ram_we_n` out 1: registered; drives RAM `we` (active-low).
- `ram_data_out` in DATA_WIDTH: RAM read data.

## Operation
- FSM has 2 states:
  - IDLE: `cmd_ready=1`; an accept moves to ACCESS.
  - ACCESS: lasts exactly one cycle, then returns to IDLE.
- Pointer `sp` (CW bits) = `count`, the next free slot.
- On the accept edge, the RAM drive registers and a latched op/error flag load:
  - PUSH, not full: `ram_addr = STACK_BASE+sp`, `ram_data_in = cmd_data`, `ram_we_n = 0`.
  - POP/PEEK, not empty: `ram_addr = STACK_BASE+sp-1`, `ram_we_n = 1`.
  - Error cases and CLEAR: `ram_addr` unchanged, `ram_we_n = 1`; no RAM access.
- The RAM writes and registers its address on the falling edge inside ACCESS. `ram_data_out` is valid by the end of ACCESS.
- At the ACCESS exit edge:
  - `rsp_valid = 1`, `ram_we_n = 1`.
  - POP/PEEK OK: `rsp_data = ram_data_out`; POP then does `sp = sp-1`.
  - PUSH OK: `sp = sp+1`.
  - CLEAR: `sp = 0`.
  - Errors: `rsp_err = 1`, `sp` unchanged, RAM contents untouched.
- `rsp_valid` and `rsp_err` drop the following cycle.
- `sp` never wraps: it is bounded by the error checks.
- `cmd_op` and `cmd_data` are ignored when not accepted.

## Timing
- Latency: accept at edge T produces `rsp_valid` in the cycle after edge T+1, for every op.
- Throughput: one command per 2 cycles. `cmd_ready` is low during ACCESS and high again in the cycle after T+1.
- `ram_we_n` is low for exactly one clock period (T to T+1), only for non-error PUSH.
- `count`, `full` and `empty` update at T+1.
- Reset values: state IDLE, `sp=0`, `count=0`, `empty=1`, `full=0`, `cmd_ready=1`, `rsp_valid=0`, `rsp_err=0`, `rsp_data=0`, `ram_addr=STACK_BASE`, `ram_data_in=0`, `ram_we_n=1`.
- Reset wins over a simultaneous accept.
- Reset at the ACCESS exit edge: outputs take reset values and no response is issued. A PUSH's mid-cycle RAM write has already landed; this is harmless because `sp=0`.
- DEPTH=1 works: push sets full; pop sets empty.

## Structure
- Package `stack_pkg`:
  - op encodings (`OP_PUSH`, `OP_POP`, `OP_PEEK`, `OP_CLEAR`);
  - state enum (`S_IDLE`, `S_ACCESS`).
- No sub-module inside `stack_ctrl`. Separate wrapper `stack_top` instantiates `stack_ctrl` plus the RAM, `clk` shared.
- Testbench uses `stack_top`.

## Test plan
- Bench config: DEPTH=4, BASE=16'h0100.
- Reset, then push 8'hA1, 8'hB2 -> each `rsp_valid` at T+2, `rsp_err=0`; RAM[0x0100]=A1, RAM[0x0101]=B2; `count=2`; `ram_we_n` low exactly 1 cycle each.
- Peek then pop, pop -> peek `rsp_data=B2`, `count` stays 2; pops return B2 then A1; `count=0`, `empty=1`.
- Pop on empty -> `rsp_err=1`, `rsp_data=0`, no RAM activity (`ram_we_n` stays 1), `count=0`.
- Push 4 words then a 5th (8'hEE) -> `full=1` after the 4th; 5th gives `rsp_err=1`; RAM[0x0103] keeps its 4th word; `count=4`.
- Push 3, CLEAR, pop -> CLEAR response with `rsp_err=0`, `count=0`; next pop errors.
- Hold `cmd_valid` high with 4 back-to-back pushes -> accepts spaced 2 cycles apart. Assert `rst_n` low at the ACCESS exit of the 3rd -> no `rsp_valid`, `count=0`, `ram_we_n=1`, `cmd_ready=1` after release.
